uarc_recv_arbiter: RTL and testbench

- Parametrised receive-side arbiter for UARC `send` traffic into a core.
- Masks incoming sends with a per-bus enable register and picks one winner per grant, by fixed priority or round-robin.
- Latches the winner's bus index and data into a one-entry holding register and returns a single-cycle ack to the sender.
- Generalises the combinational mask plus priority-encoder interrupt chooser into a sequential block with a handshake, a selectable policy and a back-to-back hand-off to the core pipeline.

---
 rtl/uarc_recv_arbiter.sv | 123 ++++++++++++
 tb/tb_uarc_recv_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uarc_recv_arbiter.sv
// Receive-side arbiter for UARC send traffic: enable mask, fixed-priority
// or round-robin pick, one-entry holding register and a one-cycle ack.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   enable_write/index/value  update one per-bus enable bit
//   receiver_sends        per-bus level requests, held until acked
//   receiver_datas        per-bus payloads
//   receiver_send_acks    registered one-hot ack pulse to the winner
//   pending               holding register full
//   pending_bus           winning bus index, zero-extended
//   pending_data          latched winner payload
//   take                  core consumes the held entry
module uarc_recv_arbiter #(
   parameter int WORD_MAG    = 5,
   parameter int TOTAL_BUSES = 4,
   parameter bit ROUND_ROBIN = 1'b1,
   localparam int WORD_WIDTH = 1 << WORD_MAG
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  enable_write,
   input  logic [WORD_WIDTH-1:0]                 enable_index,
   input  logic                                  enable_value,
   input  logic [TOTAL_BUSES-1:0]                receiver_sends,
   input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_datas,
   output logic [TOTAL_BUSES-1:0]                receiver_send_acks,
   output logic                                  pending,
   output logic [WORD_WIDTH-1:0]                 pending_bus,
   output logic [WORD_WIDTH-1:0]                 pending_data,
   input  logic                                  take
);

   localparam int PTR_W = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t state, state_next;

   logic [TOTAL_BUSES-1:0] enables;
   logic [TOTAL_BUSES-1:0] masked;
   logic [TOTAL_BUSES-1:0] win_onehot;
   logic [PTR_W-1:0]       rr_ptr;
   logic [PTR_W-1:0]       start;
   logic [PTR_W-1:0]       win_next;
   logic [WORD_WIDTH-1:0]  win_bus;
   logic [WORD_WIDTH-1:0]  win_data;
   logic                   found;
   logic                   free;
   logic                   grant;

   // An in-flight ack blocks a second grant for the same request.
   assign masked  = receiver_sends & enables & ~receiver_send_acks;
   assign free    = (state == EMPTY) | take;
   assign start   = ROUND_ROBIN ? rr_ptr : '0;
   assign grant   = free & found;
   assign pending = (state == FULL);

   // Two passes give a wrapped search: indices at/after start first,
   // then from 0 upward.
   always_comb begin
      found      = 1'b0;
      win_onehot = '0;
      win_bus    = '0;
      win_data   = '0;
      win_next   = '0;
      for (int i = 0; i < TOTAL_BUSES; i++) begin
         if (!found && masked[i] && (PTR_W'(i) >= start)) begin
            found         = 1'b1;
            win_onehot[i] = 1'b1;
            win_bus       = WORD_WIDTH'(i);
            win_data      = receiver_datas[i];
            win_next      = (i == TOTAL_BUSES - 1) ? '0 : PTR_W'(i + 1);
         end
      end
      for (int i = 0; i < TOTAL_BUSES; i++) begin
         if (!found && masked[i]) begin
            found         = 1'b1;
            win_onehot[i] = 1'b1;
            win_bus       = WORD_WIDTH'(i);
            win_data      = receiver_datas[i];
            win_next      = (i == TOTAL_BUSES - 1) ? '0 : PTR_W'(i + 1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= EMPTY;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (grant) state_next = FULL;
         FULL:    if (take && !grant) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         enables            <= '0;
         rr_ptr             <= '0;
         pending_bus        <= '0;
         pending_data       <= '0;
         receiver_send_acks <= '0;
      end else begin
         if (enable_write) begin
            for (int i = 0; i < TOTAL_BUSES; i++) begin
               if (enable_index == WORD_WIDTH'(i)) enables[i] <= enable_value;
            end
         end
         receiver_send_acks <= grant ? win_onehot : '0;
         if (grant) begin
            pending_bus  <= win_bus;
            pending_data <= win_data;
            if (ROUND_ROBIN) rr_ptr <= win_next;
         end
      end
   end

endmodule

// File: tb/tb_uarc_recv_arbiter.sv
// Directed bench for uarc_recv_arbiter: one round-robin and one
// fixed-priority instance driven by the same stimulus.
module tb_uarc_recv_arbiter;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable_write;
   logic [31:0]      enable_index;
   logic             enable_value;
   logic [3:0]       sends;
   logic [3:0][31:0] datas;
   logic             take;

   logic [3:0]  rr_acks, fp_acks;
   logic        rr_pending, fp_pending;
   logic [31:0] rr_bus, fp_bus, rr_data, fp_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uarc_recv_arbiter #(.WORD_MAG(5), .TOTAL_BUSES(4), .ROUND_ROBIN(1'b1)) dut_rr (
      .clk(clk), .reset(reset),
      .enable_write(enable_write), .enable_index(enable_index),
      .enable_value(enable_value),
      .receiver_sends(sends), .receiver_datas(datas),
      .receiver_send_acks(rr_acks), .pending(rr_pending),
      .pending_bus(rr_bus), .pending_data(rr_data), .take(take));

   uarc_recv_arbiter #(.WORD_MAG(5), .TOTAL_BUSES(4), .ROUND_ROBIN(1'b0)) dut_fp (
      .clk(clk), .reset(reset),
      .enable_write(enable_write), .enable_index(enable_index),
      .enable_value(enable_value),
      .receiver_sends(sends), .receiver_datas(datas),
      .receiver_send_acks(fp_acks), .pending(fp_pending),
      .pending_bus(fp_bus), .pending_data(fp_data), .take(take));

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_en(input int idx, input logic val);
      enable_write = 1'b1;
      enable_index = idx;
      enable_value = val;
      tick();
      enable_write = 1'b0;
   endtask

   task automatic do_reset();
      sends        = '0;
      take         = 1'b0;
      enable_write = 1'b0;
      reset        = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      enable_write = 1'b0;
      enable_index = '0;
      enable_value = 1'b0;
      sends        = '0;
      datas        = '0;
      take         = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      check("rst_pending", {31'd0, rr_pending}, 32'd0);
      check("rst_acks", {28'd0, rr_acks}, 32'd0);
      check("rst_bus", rr_bus, 32'd0);
      check("rst_data", rr_data, 32'd0);

      // async reset while full with ack in flight
      wr_en(0, 1'b1);
      sends    = 4'b0001;
      datas[0] = 32'h77;
      tick();
      check("pre_rst_pending", {31'd0, rr_pending}, 32'd1);
      check("pre_rst_ack", {28'd0, rr_acks}, 32'h1);
      #2 reset = 1'b1;
      #1;
      check("async_pending", {31'd0, rr_pending}, 32'd0);
      check("async_ack", {28'd0, rr_acks}, 32'd0);
      check("async_data", rr_data, 32'd0);
      check("async_bus", rr_bus, 32'd0);
      tick();
      reset = 1'b0;
      repeat (3) begin
         tick();
         check("no_en_pending", {31'd0, rr_pending}, 32'd0);
      end
      wr_en(0, 1'b1);
      check("en_edge_pending", {31'd0, rr_pending}, 32'd0);
      tick();
      check("en_grant_pending", {31'd0, rr_pending}, 32'd1);
      check("en_grant_data", rr_data, 32'h77);
      sends = '0;
      take  = 1'b1;
      tick();
      take = 1'b0;
      check("drain_pending", {31'd0, rr_pending}, 32'd0);

      // fixed priority
      do_reset();
      for (int i = 0; i < 4; i++) wr_en(i, 1'b1);
      sends    = 4'b1010;
      datas[1] = 32'h11;
      datas[3] = 32'h33;
      take     = 1'b1;
      tick();
      check("fp_bus_a", fp_bus, 32'd1);
      check("fp_data_a", fp_data, 32'h11);
      check("fp_ack_a", {28'd0, fp_acks}, 32'h2);
      sends = 4'b1000;
      tick();
      check("fp_bus_b", fp_bus, 32'd3);
      check("fp_data_b", fp_data, 32'h33);
      check("fp_ack_b", {28'd0, fp_acks}, 32'h8);
      sends = 4'b0000;
      tick();
      check("fp_empty", {31'd0, fp_pending}, 32'd0);
      check("fp_hold_bus", fp_bus, 32'd3);
      check("fp_ack_c", {28'd0, fp_acks}, 32'd0);
      take = 1'b0;

      // round-robin fairness, all requests held
      do_reset();
      for (int i = 0; i < 4; i++) begin
         wr_en(i, 1'b1);
         datas[i] = 32'hA0 + i;
      end
      sends = 4'b1111;
      take  = 1'b1;
      begin
         logic [31:0] rr_exp[5];
         logic [31:0] fp_exp[5];
         rr_exp = '{0, 1, 2, 3, 0};
         fp_exp = '{0, 1, 0, 1, 0};
         for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_bus", rr_bus, rr_exp[k]);
            check("rr_data", rr_data, 32'hA0 + rr_exp[k]);
            check("rr_ack", {28'd0, rr_acks}, 32'd1 << rr_exp[k]);
            check("rr_pending", {31'd0, rr_pending}, 32'd1);
            check("fp_seq_bus", fp_bus, fp_exp[k]);
         end
      end
      sends = '0;
      tick();
      take = 1'b0;

      // masking and index range
      do_reset();
      wr_en(0, 1'b1);
      wr_en(1, 1'b1);
      wr_en(3, 1'b1);
      wr_en(7, 1'b1);
      wr_en(6, 1'b1);
      sends    = 4'b0100;
      datas[2] = 32'h22;
      repeat (5) begin
         tick();
         check("mask_pending", {31'd0, rr_pending}, 32'd0);
         check("mask_ack", {28'd0, rr_acks}, 32'd0);
      end
      wr_en(2, 1'b1);
      check("mask_wr_edge", {31'd0, rr_pending}, 32'd0);
      tick();
      check("mask_grant", {31'd0, rr_pending}, 32'd1);
      check("mask_bus", rr_bus, 32'd2);
      check("mask_ack2", {28'd0, rr_acks}, 32'h4);

      // clearing an enable keeps the pending entry; full hold
      sends = '0;
      wr_en(2, 1'b0);
      check("clr_pending", {31'd0, rr_pending}, 32'd1);
      check("clr_bus", rr_bus, 32'd2);
      sends    = 4'b0010;
      datas[1] = 32'h55;
      repeat (10) begin
         tick();
         check("hold_bus", rr_bus, 32'd2);
         check("hold_data", rr_data, 32'h22);
         check("hold_ack", {28'd0, rr_acks}, 32'd0);
      end
      take = 1'b1;
      tick();
      take = 1'b0;
      check("take_bus", rr_bus, 32'd1);
      check("take_data", rr_data, 32'h55);
      check("take_ack", {28'd0, rr_acks}, 32'h2);
      check("take_fp_bus", fp_bus, 32'd1);
      sends = '0;
      tick();
      check("after_ack", {28'd0, rr_acks}, 32'd0);
      check("after_pending", {31'd0, rr_pending}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
